// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the instruction-fetch slice.
//   - if_state_e       : fetch FSM state encoding (IDLE, REQ, HOLD)
//   - OPCODE_*/TARGET_*: instruction field slice positions
//   - DEFAULT_RESET_PC : PC loaded on reset unless overridden
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } if_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4      in  32  PC+4 of the retiring instruction
//   jump          in   1  jump request (highest priority)
//   jump_target   in  26  instr[25:0] of the retiring instruction
//   branch_taken  in   1  taken branch request
//   branch_offset in  32  sign-extended offset, in words
//   next_pc       out 32  selected next PC, word aligned
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] next_pc
);

  logic [31:0] jump_pc;
  logic [31:0] branch_pc;
  logic [31:0] sel_pc;

  // Jump keeps the 256 MB region of the delay-slot address.
  assign jump_pc   = {pc_plus4[31:28], jump_target, 2'b00};
  // Word offset scaled to bytes; modulo-2^32 so negative offsets wrap.
  assign branch_pc = pc_plus4 + (branch_offset << 2);

  always_comb begin
    sel_pc = pc_plus4;
    if (jump) begin
      sel_pc = jump_pc;
    end else if (branch_taken) begin
      sel_pc = branch_pc;
    end
  end

  assign next_pc = {sel_pc[31:2], 2'b00};

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage. Owns the PC, fetches one word per
// req/ack transaction, holds it for downstream and drives the opcode into
// the main control decoder. The redirect is applied when the held word
// retires (HOLD with stall=0).
//
// Handshake: imem_req rises in REQ and stays high, with imem_addr stable,
// until a cycle where imem_ack=1; imem_rdata is captured in that same cycle
// and imem_req drops on the next edge. Acks outside REQ are ignored.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   imem_req/addr         fetch request and word-aligned address (= PC)
//   imem_ack/rdata        memory response
//   stall                 downstream not ready; freezes HOLD
//   branch_taken/offset   branch redirect from the datapath
//   jump/jump_target      jump redirect from the decoder
//   instr/opcode          held instruction and its opcode field
//   pc_plus4              PC+4 of the held instruction
//   instr_valid           held instruction is valid
//   dbg_state             current FSM state for observation
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output if_state_e   dbg_state
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;

  assign pc_plus4 = pc_q + 32'd4;

  pc_next_sel u_pc_next_sel (
    .pc_plus4     (pc_plus4),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .next_pc      (pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          // Redirect inputs only matter on the retire edge.
          if (!stall) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign instr_valid = valid_q;
  assign dbg_state   = state_q;

endmodule
